// File: rtl/pipe_spawn_pkg.sv
// Shared types and constants for the pipe spawn scheduler.
// The LFSR tap table is only consumed when SPAWN_LFSR_GAP_EN is defined.
package pipe_spawn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        WAIT  = 2'd2,
        STALL = 2'd3
    } state_t;

    localparam logic [15:0] SPAWN_CNT_MAX = 16'hFFFF;

    // Maximal-length Fibonacci feedback masks; bit n-1 set for tap n.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h00B8;
        endcase
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Width-parametrised Fibonacci LFSR, seeded to 1 on reset, stepping every clock.
// Used by pipe_spawn_sched only when SPAWN_LFSR_GAP_EN is defined.
module pipe_lfsr
    import pipe_spawn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    output logic [WIDTH-1:0] o_Value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    assign lfsr_d  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign o_Value = lfsr_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            lfsr_q <= WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/pipe_spawn_sched.sv
// Round-robin pipe spawn scheduler: launches pipes at a tick interval, stalls on busy pipes.
// Optional random gap height output is enabled by defining SPAWN_LFSR_GAP_EN.
module pipe_spawn_sched
    import pipe_spawn_pkg::*;
#(
    parameter int NUM_PIPES      = 3,
    parameter int SPAWN_INTERVAL = 3
`ifdef SPAWN_LFSR_GAP_EN
    ,
    parameter int GAP_W          = 8
`endif
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic                 i_Stop,
    input  logic                 i_Pause,
    input  logic                 i_Tick,
    input  logic [NUM_PIPES-1:0] i_Pipe_Done,
    output logic [NUM_PIPES-1:0] o_Pipe_Start,
    output logic [NUM_PIPES-1:0] o_Pipe_Active,
    output logic [15:0]          o_Spawn_Count,
    output logic                 o_Stalled
`ifdef SPAWN_LFSR_GAP_EN
    ,
    output logic [GAP_W-1:0]     o_Gap_Y
`endif
);

    localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);
    localparam int PTR_W = $clog2(NUM_PIPES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PIPES - 1);

    state_t               state_q,  state_d;
    logic [PTR_W-1:0]     ptr_q,    ptr_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [NUM_PIPES-1:0] active_q, active_d;
    logic [NUM_PIPES-1:0] pulse_q,  pulse_d;
    logic [15:0]          count_q,  count_d;
    logic                 stalled_q, stalled_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        // The spawn pulse sets its pipe's flag after the clear, so a same-cycle done loses.
        active_d = (active_q & ~i_Pipe_Done) | pulse_q;

        case (state_q)
            IDLE: begin
                if (i_Start && !i_Stop) begin
                    state_d = SPAWN;
                    count_d = '0;
                end
            end
            SPAWN: begin
                state_d = WAIT;
                ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                cnt_d   = '0;
                count_d = (count_q == SPAWN_CNT_MAX) ? count_q : count_q + 16'd1;
            end
            WAIT: begin
                if (i_Tick && !i_Pause) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = active_q[ptr_q] ? STALL : SPAWN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STALL: begin
                if (!active_q[ptr_q]) begin
                    state_d = SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop overrides everything, but the spawn count is kept for the score display.
        if (i_Stop && state_q != IDLE) begin
            state_d  = IDLE;
            ptr_d    = '0;
            cnt_d    = '0;
            active_d = '0;
            count_d  = count_q;
        end

        pulse_d = '0;
        if (state_d == SPAWN) begin
            pulse_d[ptr_d] = 1'b1;
        end
        stalled_d = (state_d == STALL);
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
        if (i_Reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            pulse_q   <= '0;
            count_q   <= '0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            stalled_q <= stalled_d;
        end
    end

    assign o_Pipe_Start  = pulse_q;
    assign o_Pipe_Active = active_q;
    assign o_Spawn_Count = count_q;
    assign o_Stalled     = stalled_q;

`ifdef SPAWN_LFSR_GAP_EN
    logic [GAP_W-1:0] lfsr_val;
    logic [GAP_W-1:0] gap_q;

    pipe_lfsr #(
        .WIDTH (GAP_W)
    ) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .o_Value (lfsr_val)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            gap_q <= '0;
        end else if (state_q == SPAWN) begin
            gap_q <= lfsr_val;
        end
    end

    assign o_Gap_Y = gap_q;
`endif

endmodule

// File: tb/tb_pipe_spawn_sched.sv
// Directed self-checking bench for pipe_spawn_sched (NUM_PIPES=3, SPAWN_INTERVAL=3).
// Also checks o_Gap_Y against a reference LFSR when SPAWN_LFSR_GAP_EN is defined.
module tb_pipe_spawn_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       tick;
    logic [2:0] done;
    logic [2:0] pipe_start;
    logic [2:0] pipe_active;
    logic [15:0] spawn_count;
    logic       stalled;
`ifdef SPAWN_LFSR_GAP_EN
    logic [7:0] gap_y;
    logic [7:0] lfsr_m;
    logic [7:0] gap_exp;
`endif

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    pipe_spawn_sched #(
        .NUM_PIPES      (3),
        .SPAWN_INTERVAL (3)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Start       (start),
        .i_Stop        (stop),
        .i_Pause       (pause),
        .i_Tick        (tick),
        .i_Pipe_Done   (done),
        .o_Pipe_Start  (pipe_start),
        .o_Pipe_Active (pipe_active),
        .o_Spawn_Count (spawn_count),
        .o_Stalled     (stalled)
`ifdef SPAWN_LFSR_GAP_EN
        ,
        .o_Gap_Y       (gap_y)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SPAWN_LFSR_GAP_EN
    // Reference x^8+x^6+x^5+x^4+1 Fibonacci LFSR, seed 1.
    always @(posedge clk) begin
        if (rst) lfsr_m <= 8'h01;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic run_to(input int t);
        while (cyc_no < t) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; tick = 1'b0; done = 3'b000;
        cyc();
        cyc();
        check("rst_start",   32'(pipe_start),  32'h0);
        check("rst_active",  32'(pipe_active), 32'h0);
        check("rst_count",   32'(spawn_count), 32'h0);
        check("rst_stalled", 32'(stalled),     32'h0);
        rst = 1'b0;

        // Basic round-robin sequence with pipe 0 recycled in time.
        cyc_no = 0; start = 1'b1; tick = 1'b1;
        run_to(1);
        check("basic_p1", 32'(pipe_start), 32'h1);
        check("basic_cnt_in_spawn", 32'(spawn_count), 32'h0);
`ifdef SPAWN_LFSR_GAP_EN
        gap_exp = lfsr_m;
`endif
        start = 1'b0;
        run_to(2);
        check("basic_act2", 32'(pipe_active), 32'h1);
        check("basic_cnt2", 32'(spawn_count), 32'h1);
        check("basic_idle2", 32'(pipe_start), 32'h0);
`ifdef SPAWN_LFSR_GAP_EN
        check("gap_after_spawn1", 32'(gap_y), 32'(gap_exp));
        run_to(4);
        check("gap_hold", 32'(gap_y), 32'(gap_exp));
`endif
        run_to(4);
        check("basic_nopulse4", 32'(pipe_start), 32'h0);
        run_to(5);
        check("basic_p5", 32'(pipe_start), 32'h2);
`ifdef SPAWN_LFSR_GAP_EN
        gap_exp = lfsr_m;
`endif
        run_to(6);
`ifdef SPAWN_LFSR_GAP_EN
        check("gap_after_spawn2", 32'(gap_y), 32'(gap_exp));
`endif
        done = 3'b001;
        run_to(7);
        done = 3'b000;
        check("basic_done_clear", 32'(pipe_active), 32'h2);
        run_to(9);
        check("basic_p9", 32'(pipe_start), 32'h4);
        run_to(13);
        check("basic_p13", 32'(pipe_start), 32'h1);
        check("basic_nostall", 32'(stalled), 32'h0);
        run_to(14);
        check("basic_cnt14", 32'(spawn_count), 32'h4);
        check("basic_act14", 32'(pipe_active), 32'h7);

        // Stall when pipe 0 has not come back, released by a done pulse.
        do_reset();
        cyc_no = 0; start = 1'b1; tick = 1'b1;
        run_to(1);
        start = 1'b0;
        run_to(13);
        check("stall_flag", 32'(stalled), 32'h1);
        check("stall_nopulse", 32'(pipe_start), 32'h0);
        run_to(20);
        done = 3'b001;
        run_to(21);
        done = 3'b000;
        check("stall_act21", 32'(pipe_active), 32'h6);
        check("stall_still21", 32'(stalled), 32'h1);
        run_to(22);
        check("stall_release_p", 32'(pipe_start), 32'h1);
        check("stall_release_f", 32'(stalled), 32'h0);
        run_to(23);
        check("stall_cnt", 32'(spawn_count), 32'h4);

        // Pause for ten cycles mid-WAIT, then quarter-rate ticks.
        do_reset();
        cyc_no = 0; start = 1'b1; tick = 1'b1;
        run_to(1);
        start = 1'b0;
        run_to(6);
        pause = 1'b1;
        run_to(10);
        done = 3'b001;
        run_to(11);
        done = 3'b000;
        run_to(16);
        pause = 1'b0;
        run_to(18);
        check("pause_nopulse18", 32'(pipe_start), 32'h0);
        run_to(19);
        check("pause_p19", 32'(pipe_start), 32'h4);
        while (cyc_no < 31) begin
            tick = (cyc_no % 4 == 3);
            cyc();
        end
        check("slow_nopulse31", 32'(pipe_start), 32'h0);
        tick = (cyc_no % 4 == 3);
        cyc();
        check("slow_p32", 32'(pipe_start), 32'h1);
        tick = 1'b1;

        // Stop during WAIT with pipes 0 and 1 busy, then restart.
        do_reset();
        cyc_no = 0; start = 1'b1;
        run_to(1);
        start = 1'b0;
        run_to(7);
        check("stop_pre_act", 32'(pipe_active), 32'h3);
        stop = 1'b1;
        run_to(8);
        stop = 1'b0;
        check("stop_act", 32'(pipe_active), 32'h0);
        check("stop_nopulse", 32'(pipe_start), 32'h0);
        check("stop_cnt_hold", 32'(spawn_count), 32'h2);
        run_to(9);
        check("stop_idle9", 32'(pipe_start), 32'h0);
        cyc_no = 0; start = 1'b1;
        run_to(1);
        start = 1'b0;
        check("restart_p0", 32'(pipe_start), 32'h1);
        check("restart_cnt0", 32'(spawn_count), 32'h0);
        run_to(2);
        check("restart_cnt1", 32'(spawn_count), 32'h1);

        // Done on the pipe being spawned, done on an idle pipe, reset mid-WAIT.
        do_reset();
        cyc_no = 0; start = 1'b1;
        run_to(1);
        start = 1'b0;
        run_to(5);
        done = 3'b010;
        run_to(6);
        check("same_cycle_set", 32'(pipe_active), 32'h3);
        done = 3'b100;
        run_to(7);
        done = 3'b000;
        check("idle_done_ignored", 32'(pipe_active), 32'h3);
        rst = 1'b1;
        run_to(8);
        rst = 1'b0;
        check("midrst_start",  32'(pipe_start),  32'h0);
        check("midrst_active", 32'(pipe_active), 32'h0);
        check("midrst_count",  32'(spawn_count), 32'h0);
        check("midrst_stall",  32'(stalled),     32'h0);

        // Start and stop together in IDLE must not leave IDLE.
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("startstop_a", 32'(pipe_start), 32'h0);
        cyc();
        check("startstop_b", 32'(pipe_start), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_spawn_sched.md
Name: pipe_spawn_sched

Overview:
- Parametrised successor to the three-pipe spawn controller.
- Round-robin scheduler that launches NUM_PIPES pipe objects at a fixed tick interval.
- Tracks which pipes are still on screen, stalls when the next pipe has not been recycled, and supports pause and stop.
- Sits between the game-state FSM (start/stop/pause) and the per-pipe movement blocks.

Parameters:
- NUM_PIPES, 3, number of pipe channels; legal range 2..16.
- SPAWN_INTERVAL, 3, number of i_Tick pulses between spawns; must be at least 1.
- CNT_W, $clog2(SPAWN_INTERVAL+1), derived localparam giving the interval counter width; not overridable.
- GAP_W, 8, width of o_Gap_Y; used only when the optional feature is enabled.

Ports:
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Reset  in  1  reset, synchronous and active-high.
- i_Start  in  1  level input; starts spawning when sampled high in IDLE.
- i_Stop  in  1  abort request (game over); highest priority of all inputs.
- i_Pause  in  1  freezes the interval counter while high.
- i_Tick  in  1  frame-rate enable; the interval counter advances only on cycles where it is high.
- i_Pipe_Done  in  NUM_PIPES  one-cycle pulse per pipe when that pipe has left the screen.
- o_Pipe_Start  out  NUM_PIPES  one-hot, one-cycle pulse launching pipe k.
- o_Pipe_Active  out  NUM_PIPES  registered busy flag per pipe.
- o_Spawn_Count  out  16  total spawns since the last start; saturates at 16'hFFFF.
- o_Stalled  out  1  high while in STALL.

Behaviour:
- Reset (synchronous, active-high, sampled at a clock edge): state=IDLE, ptr=0, cnt=0; all outputs 0. Reset overrides every other input.
- IDLE: i_Start=1 at an edge -> SPAWN in the next cycle. o_Spawn_Count is cleared on this transition.
- SPAWN (exactly one cycle, Moore output): o_Pipe_Start[ptr]=1; o_Pipe_Active[ptr] is set at the end of the cycle; ptr advances as (ptr+1) mod NUM_PIPES; cnt clears to 0; o_Spawn_Count increments (saturating); next state WAIT.
- WAIT: cnt increments on i_Tick & ~i_Pause.
  - When cnt==SPAWN_INTERVAL-1 and i_Tick & ~i_Pause: go to STALL if o_Pipe_Active[ptr]=1, otherwise go to SPAWN.
  - With i_Tick held high and no pause, spawn pulses occur every SPAWN_INTERVAL+1 clocks.
- STALL: leave for SPAWN on the first cycle in which registered o_Pipe_Active[ptr]==0. i_Pause does not block this exit.
- Done handling:
  - i_Pipe_Done[k] clears o_Pipe_Active[k] at the end of the cycle.
  - If Done[k] and a SPAWN of k occur in the same cycle, the set wins (active stays 1).
  - A Done on a pipe that is already inactive is ignored.
- i_Stop: from any non-IDLE state -> IDLE next cycle; clears ptr, cnt and all active flags; no pulse is emitted in that cycle. o_Spawn_Count holds its value until the next start.
- i_Start held high in non-IDLE states is ignored. i_Start and i_Stop high together in IDLE -> remain in IDLE.
- Counter: CNT_W bits; never exceeds SPAWN_INTERVAL-1. SPAWN_INTERVAL=1 means one tick per spawn.
- o_Pipe_Start is never more than one-hot.

Optional Feature:
- Macro: SPAWN_LFSR_GAP_EN.
- When defined:
  - Adds port o_Gap_Y (out, GAP_W bits).
  - A GAP_W-bit maximal-length Fibonacci LFSR with reset seed 1 advances every clock.
  - o_Gap_Y latches the LFSR value in each SPAWN cycle, is valid from the cycle after the pulse, and holds until the next spawn.
- When not defined: no port and no LFSR; all other behaviour is identical.

Decomposition:
- Package pipe_spawn_pkg: state enum (IDLE, SPAWN, WAIT, STALL) as a 2-bit typedef, LFSR tap constants indexed by GAP_W, and the saturating max for the spawn count.
- One natural sub-module, pipe_lfsr (width-parametrised LFSR), instantiated only under SPAWN_LFSR_GAP_EN.

Test Plan:
- Basic sequence (NUM_PIPES=3, SPAWN_INTERVAL=3, i_Tick=1): reset, then i_Start=1 -> o_Pipe_Start = 001, 010, 100, 001 at cycles 1, 5, 9, 13 after start; o_Spawn_Count=4.
- Stall: same setup with no i_Pipe_Done -> STALL after the third spawn, o_Stalled=1. Pulse i_Pipe_Done[0] at cycle 20 -> o_Pipe_Start=001 at cycle 22.
- Pause: i_Pause=1 for 10 cycles mid-WAIT -> the next spawn is delayed by exactly 10 cycles; i_Tick toggling at 1/4 rate stretches the spacing to 4·3+1=13 clocks.
- Stop mid-run: i_Stop during WAIT with active=011 -> next cycle state=IDLE, o_Pipe_Active=000, no pulse. A restart begins at pipe 0 and the count clears to 1 after the first spawn.
- Same-cycle done and spawn: i_Pipe_Done[1] in the SPAWN cycle of pipe 1 -> o_Pipe_Active[1] stays 1. Reset asserted mid-WAIT -> all outputs 0 at the next edge.
- With SPAWN_LFSR_GAP_EN (GAP_W=8): o_Gap_Y matches a reference LFSR model at each spawn and is stable between spawns.
